// File: rtl/reg2mem_pkg.sv
// reg2mem_pkg: opcodes, FSM state encoding and instruction field positions shared by reg2mem_ctrl
package reg2mem_pkg;
  localparam int INSTR_W = 10;
  localparam int IMM_W = 4;
  localparam int OP_LSB = 8;
  localparam int FLD_LSB = 4;
  localparam int ADDR_LSB = 0;
  localparam logic [1:0] OP_STORE = 2'd0;
  localparam logic [1:0] OP_TO_MEM = 2'd1;
  localparam logic [1:0] OP_FROM_MEM = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE,
    S_REG_RD,
    S_MEM_RD,
    S_WAIT,
    S_MEM_WR,
    S_REG_WR,
    S_RESP
  } state_e;
endpackage

// File: rtl/reg2mem_ctrl_if.sv
// reg2mem_ctrl_if: instruction, storage-control and result signals of the reg2mem sequencer
//   master: the controller (drives storage pins, instr_ready, busy, res/res_valid)
//   slave : instruction source, storage blocks and result consumer
interface reg2mem_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int MEM_AW = 4,
  parameter int REG_AW = 3
);
  logic instr_valid;
  logic instr_ready;
  logic [9:0] instruction;
  logic busy;
  logic reg_en;
  logic reg_we;
  logic [REG_AW-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic mem_en;
  logic mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] res;
  logic res_valid;
  logic res_ready;
  modport master (
    input instr_valid, instruction, reg_rdata, mem_rdata, res_ready,
    output instr_ready, busy, reg_en, reg_we, reg_addr, reg_wdata,
    output mem_en, mem_we, mem_addr, mem_wdata, res, res_valid
  );
  modport slave (
    output instr_valid, instruction, reg_rdata, mem_rdata, res_ready,
    input instr_ready, busy, reg_en, reg_we, reg_addr, reg_wdata,
    input mem_en, mem_we, mem_addr, mem_wdata, res, res_valid
  );
endinterface

// File: rtl/reg2mem_ctrl.sv
// reg2mem_ctrl: serialising sequencer moving data between an 8x4 register file and a 16x4 block memory
//   clk, rst : clock and async active-high reset
//   bus      : instruction handshake, register-file and memory control pins, result channel
module reg2mem_ctrl
  import reg2mem_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int MEM_AW = 4,
  parameter int REG_AW = 3,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  reg2mem_ctrl_if.master bus
);
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  state_e state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] cap_q, cap_d, res_q, res_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d, mem_wdata_q, mem_wdata_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic busy_q, busy_d, res_valid_q, res_valid_d;
  logic reg_en_q, reg_en_d, reg_we_q, reg_we_d, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [1:0] op_in, op_q, op_d;
  assign op_in = bus.instruction[OP_LSB +: 2];
  assign op_q = instr_q[OP_LSB +: 2];
  assign op_d = instr_d[OP_LSB +: 2];
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d = cnt_q;
    cap_d = cap_q;
    case (state_q)
      S_IDLE: if (bus.instr_valid) begin
        instr_d = bus.instruction;
        state_d = op_in == OP_STORE ? S_MEM_WR : op_in == OP_TO_MEM ? S_REG_RD : S_MEM_RD;
      end
      S_REG_RD, S_MEM_RD: begin
        state_d = S_WAIT;
        cnt_d = CW'(RD_LAT - 1);
      end
      S_WAIT: if (cnt_q == '0) begin
        cap_d = op_q == OP_TO_MEM ? bus.reg_rdata : bus.mem_rdata;
        state_d = op_q == OP_TO_MEM ? S_MEM_WR : op_q == OP_FROM_MEM ? S_REG_WR : S_RESP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      S_MEM_WR, S_REG_WR: state_d = S_IDLE;
      S_RESP: state_d = bus.res_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  // Outputs are decoded from the next state so that, once registered, they line up with the state they describe.
  always_comb begin
    reg_en_d = state_d == S_REG_RD || state_d == S_REG_WR;
    reg_we_d = state_d == S_REG_WR;
    mem_en_d = state_d == S_MEM_RD || state_d == S_MEM_WR;
    mem_we_d = state_d == S_MEM_WR;
    reg_addr_d = reg_en_d ? instr_d[FLD_LSB +: REG_AW] : '0;
    reg_wdata_d = reg_we_d ? cap_d : '0;
    mem_addr_d = mem_en_d ? instr_d[ADDR_LSB +: MEM_AW] : '0;
    mem_wdata_d = !mem_we_d ? '0 : op_d == OP_STORE ? DATA_W'(instr_d[FLD_LSB +: IMM_W]) : cap_d;
    res_valid_d = state_d == S_RESP;
    res_d = res_valid_d ? cap_d : res_q;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      cnt_q <= '0;
      cap_q <= '0;
      res_q <= '0;
      res_valid_q <= 1'b0;
      busy_q <= 1'b0;
      reg_en_q <= 1'b0;
      reg_we_q <= 1'b0;
      reg_addr_q <= '0;
      reg_wdata_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q <= cnt_d;
      cap_q <= cap_d;
      res_q <= res_d;
      res_valid_q <= res_valid_d;
      busy_q <= busy_d;
      reg_en_q <= reg_en_d;
      reg_we_q <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign bus.instr_ready = state_q == S_IDLE;
  assign bus.busy = busy_q;
  assign bus.reg_en = reg_en_q;
  assign bus.reg_we = reg_we_q;
  assign bus.reg_addr = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.mem_en = mem_en_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.res = res_q;
  assign bus.res_valid = res_valid_q;
endmodule

// File: tb/tb_reg2mem_ctrl.sv
// tb_reg2mem_ctrl: drives RD_LAT=1 and RD_LAT=3 controllers with one instruction stream against a reference model
module tb_reg2mem_ctrl;
  import reg2mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mdl_clr = 1'b1;
  logic instr_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [9:0] instruction = '0;
  int checks = 0;
  int passed = 0;
  logic [3:0] ref_mem [16];
  logic [3:0] ref_rf [8];
  logic [3:0] last_res;
  logic [3:0] strb_w [2];
  logic busy_w [2];
  logic rdy_w [2];
  logic rv_w [2];
  logic zero_w [2];
  logic [3:0] res_w [2];
  logic [63:0] mem_w [2];
  logic [31:0] rf_w [2];
  always #5 clk = ~clk;
  function automatic logic [63:0] pk_m(input logic [3:0] a [16]);
    logic [63:0] v = '0;
    for (int i = 0; i < 16; i++) v[i*4 +: 4] = a[i];
    return v;
  endfunction
  function automatic logic [31:0] pk_r(input logic [3:0] a [8]);
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*4 +: 4] = a[i];
    return v;
  endfunction
  function automatic int lat(input int k);
    return k == 0 ? 1 : 3;
  endfunction
  for (genvar k = 0; k < 2; k++) begin : g
    localparam int L = k == 0 ? 1 : 3;
    reg2mem_ctrl_if #(.DATA_W(4), .MEM_AW(4), .REG_AW(3)) bus ();
    reg2mem_ctrl #(.DATA_W(4), .MEM_AW(4), .REG_AW(3), .RD_LAT(L)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [3:0] mem [16];
    logic [3:0] rf [8];
    logic [3:0] mpipe [L];
    logic [3:0] rpipe [L];
    assign bus.instr_valid = instr_valid;
    assign bus.instruction = instruction;
    assign bus.res_ready = res_ready;
    assign bus.mem_rdata = mpipe[L-1];
    assign bus.reg_rdata = rpipe[L-1];
    // Storage models: synchronous read with L cycles of latency; junk on the read bus outside valid reads.
    always @(posedge clk) begin
      if (mdl_clr) begin
        for (int i = 0; i < 16; i++) mem[i] <= '0;
        for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.reg_en && bus.reg_we) rf[bus.reg_addr] <= bus.reg_wdata;
      end
      mpipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 4'($urandom);
      rpipe[0] <= (bus.reg_en && !bus.reg_we) ? rf[bus.reg_addr] : 4'($urandom);
      for (int i = 1; i < L; i++) begin
        mpipe[i] <= mpipe[i-1];
        rpipe[i] <= rpipe[i-1];
      end
    end
    assign strb_w[k] = {bus.reg_en, bus.reg_we, bus.mem_en, bus.mem_we};
    assign busy_w[k] = bus.busy;
    assign rdy_w[k] = bus.instr_ready;
    assign rv_w[k] = bus.res_valid;
    assign res_w[k] = bus.res;
    assign zero_w[k] = (bus.reg_en || (bus.reg_addr == '0 && bus.reg_wdata == '0)) &&
                       (bus.mem_en || (bus.mem_addr == '0 && bus.mem_wdata == '0));
    assign mem_w[k] = pk_m(mem);
    assign rf_w[k] = pk_r(rf);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // Strobe schedule {reg_en,reg_we,mem_en,mem_we} for busy cycle i (1 = first cycle after accept).
  function automatic logic [3:0] exp_strb(input logic [1:0] op, input int i, input int l);
    case (op)
      OP_STORE: return i == 1 ? 4'b0011 : 4'b0000;
      OP_TO_MEM: return i == 1 ? 4'b1000 : i == l + 2 ? 4'b0011 : 4'b0000;
      OP_FROM_MEM: return i == 1 ? 4'b0010 : i == l + 2 ? 4'b1100 : 4'b0000;
      default: return i == 1 ? 4'b0010 : 4'b0000;
    endcase
  endfunction
  function automatic int exp_len(input logic [1:0] op, input int l, input logic [63:0] rp);
    if (op == OP_STORE) return 1;
    if (op != OP_LOAD) return l + 2;
    for (int i = l + 2; i < 64; i++) if (rp[i]) return i;
    return 64;
  endfunction
  // Issue one instruction at a negedge with both DUTs idle; rp[i] is res_ready during busy cycle i.
  task automatic run(input logic [9:0] ins, input logic [63:0] rp);
    logic [1:0] op = ins[9:8];
    logic [3:0] a = ins[3:0];
    logic [2:0] f = ins[6:4];
    logic [3:0] exp_res = ref_mem[a];
    int len [2];
    bit done [2] = '{1'b0, 1'b0};
    case (op)
      OP_STORE: ref_mem[a] = ins[7:4];
      OP_TO_MEM: ref_mem[a] = ref_rf[f];
      OP_FROM_MEM: ref_rf[f] = ref_mem[a];
      default: last_res = exp_res;
    endcase
    for (int k = 0; k < 2; k++) len[k] = exp_len(op, lat(k), rp);
    instruction = ins;
    instr_valid = 1'b1;
    res_ready = rp[0];
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruction = 10'($urandom);
    for (int i = 1; i < 40; i++) begin
      res_ready = rp[i];
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (!done[k]) begin
        chk($sformatf("strobe%0d c%0d", k, i), strb_w[k], exp_strb(op, i, lat(k)));
        chk($sformatf("busy%0d c%0d", k, i), busy_w[k], i <= len[k]);
        chk($sformatf("ready%0d c%0d", k, i), rdy_w[k], i > len[k]);
        chk($sformatf("res_valid%0d c%0d", k, i), rv_w[k], op == OP_LOAD && i >= lat(k) + 2 && i <= len[k]);
        chk($sformatf("idle_zero%0d c%0d", k, i), zero_w[k], 1);
        if (op == OP_LOAD && i >= lat(k) + 2 && i <= len[k]) chk($sformatf("res%0d", k), res_w[k], exp_res);
        if (i > len[k]) begin
          chk($sformatf("res_hold%0d", k), res_w[k], last_res);
          done[k] = 1'b1;
        end
      end
      if (done[0] && done[1]) break;
      @(posedge clk);
      #1;
    end
    if (!(done[0] && done[1])) chk("timeout", 0, 1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mem%0d", k), mem_w[k], pk_m(ref_mem));
      chk($sformatf("rf%0d", k), rf_w[k], pk_r(ref_rf));
    end
  endtask
  task automatic reset_mid_op();
    instruction = 10'b01_0101_1100;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_strobe%0d", k), strb_w[k], 4'b0000);
      chk($sformatf("rst_busy%0d", k), busy_w[k], 0);
      chk($sformatf("rst_zero%0d", k), zero_w[k], 1);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready%0d", k), rdy_w[k], 1);
      chk($sformatf("rst_mem%0d", k), mem_w[k], pk_m(ref_mem));
      chk($sformatf("rst_res%0d", k), res_w[k], 0);
    end
    @(negedge clk);
  endtask
  initial begin
    logic [63:0] rp;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    last_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_strobe%0d", k), strb_w[k], 4'b0000);
      chk($sformatf("reset_busy%0d", k), busy_w[k], 0);
      chk($sformatf("reset_rv%0d", k), rv_w[k], 0);
      chk($sformatf("reset_res%0d", k), res_w[k], 0);
      chk($sformatf("reset_zero%0d", k), zero_w[k], 1);
    end
    rst = 1'b0;
    mdl_clr = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("reset_ready%0d", k), rdy_w[k], 1);
    @(negedge clk);
    run(10'b00_1010_0011, '1);
    run(10'b00_0111_0000, '1);
    run(10'b10_0101_0000, '1);
    run(10'b01_0101_1100, '1);
    run(10'b00_1110_1001, '1);
    run(10'b10_0010_1001, '1);
    run(10'b00_0101_0100, '1);
    run(10'b11_0000_0100, ~64'h1f);
    run(10'b00_0011_1100, '1);
    reset_mid_op();
    for (int a = 0; a < 16; a++) run({2'b00, 4'($urandom), 4'(a)}, '1);
    for (int n = 0; n < 60; n++) begin
      rp = {32'($urandom), 32'($urandom)} | ~64'hfffff;
      run(10'($urandom), rp);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
